// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential accumulator ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_XOR_OR = 3'b010;
    localparam logic [2:0] OP_ANY    = 3'b011;
    localparam logic [2:0] OP_ALL    = 3'b100;
    localparam logic [2:0] OP_CAT    = 3'b101;
    localparam logic [2:0] OP_MUL    = 3'b110;
    localparam logic [2:0] OP_CLR    = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// The go edge already folds in bit 0, so the product is ready after WIDTH edges.
module mul_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;
    logic               running_q;
    logic               valid_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (go && !running_q) begin
                acc_q     <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand_q   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier_q  <= b >> 1;
                count_q   <= CW'(1);
                running_q <= 1'b1;
            end else if (running_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + CW'(1);
                if (count_q == LAST) begin
                    running_q <= 1'b0;
                    valid_q   <= 1'b1;
                end
            end
        end
    end

    // Busy spans the hand-off cycle so the caller sees exactly WIDTH busy cycles.
    assign busy    = running_q | valid_q;
    assign valid   = valid_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_seq_accum.sv
// Registered 8-op ALU with accumulator feedback, start/busy/done handshake
// and a multi-cycle multiply delegated to mul_shift_add.
module alu_seq_accum
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               b_sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int RW = 2 * WIDTH;

    state_t             state_q;
    state_t             state_d;
    logic [RW-1:0]      result_q;
    logic [RW-1:0]      op_result;
    logic               done_q;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               accept;
    logic               mul_go;
    logic               load_single;
    logic               load_mul;
    logic               mul_busy;
    logic               mul_valid;
    logic [RW-1:0]      mul_product;

    // Accumulator feedback takes only the low half; the upper half is dropped.
    assign accept = (state_q == S_IDLE) && start;
    assign b_eff  = b_sel ? b_in : result_q[WIDTH-1:0];
    assign sum    = {1'b0, a_in} + {1'b0, b_eff};
    assign diff   = {1'b0, a_in} - {1'b0, b_eff};

    always_comb begin
        op_result = '0;
        case (op)
            OP_ADD:    op_result = RW'(sum);
            OP_SUB:    op_result = RW'(diff);
            OP_XOR_OR: op_result = {a_in | b_eff, a_in ^ b_eff};
            OP_ANY:    op_result = RW'(|{a_in, b_eff});
            OP_ALL:    op_result = RW'(&{a_in, b_eff});
            OP_CAT:    op_result = {a_in, b_eff};
            default:   op_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && op == OP_MUL) state_d = S_MUL;
            S_MUL:  if (mul_valid)              state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_go      = 1'b0;
        load_single = 1'b0;
        load_mul    = 1'b0;
        case (state_q)
            S_IDLE: begin
                mul_go      = accept && (op == OP_MUL);
                load_single = accept && (op != OP_MUL);
            end
            S_MUL:   load_mul = mul_valid;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= load_single | load_mul;
            if (load_single) begin
                result_q <= op_result;
            end else if (load_mul) begin
                result_q <= mul_product;
            end
        end
    end

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .resetn  (resetn),
        .go      (mul_go),
        .a       (a_in),
        .b       (b_eff),
        .busy    (mul_busy),
        .valid   (mul_valid),
        .product (mul_product)
    );

    assign busy   = mul_busy;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_seq_accum.sv
// Scoreboard bench for alu_seq_accum at WIDTH=4: expected results are queued
// when a request is driven and compared when done is observed.
module tb_alu_seq_accum;
    import alu_pkg::*;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [2:0] op;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       b_sel;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic [7:0] exp_q[$];
    int         compared;
    int         mismatched;

    alu_seq_accum #(
        .WIDTH (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .b_sel  (b_sel),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at a negedge; the request is sampled at the following posedge.
    task automatic apply_stimulus(input logic [2:0] o, input logic [3:0] a,
                                  input logic [3:0] b, input logic bs,
                                  input logic [7:0] expected);
        op    = o;
        a_in  = a;
        b_in  = b;
        b_sel = bs;
        start = 1'b1;
        exp_q.push_back(expected);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b1;
        op     = OP_ADD;
        a_in   = 4'h5;
        b_in   = 4'h3;
        b_sel  = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (result !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_result: got %h expected %h", result, 8'h00);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        start  = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_done cycle %0d: got %b expected 0", i, done);
            end
        end
    endtask

    task automatic test_single_ops();
        logic [2:0] v_op [4];
        logic [3:0] v_a  [4];
        logic [3:0] v_b  [4];
        logic [7:0] v_e  [4];
        logic [7:0] expected;
        v_op = '{OP_ADD, OP_SUB, OP_CAT, OP_XOR_OR};
        v_a  = '{4'hF, 4'h2, 4'hA, 4'hC};
        v_b  = '{4'h1, 4'h5, 4'h5, 4'hA};
        v_e  = '{8'h10, 8'h1D, 8'hA5, 8'hE6};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(v_op[i], v_a[i], v_b[i], 1'b1, v_e[i]);
            @(negedge clk);
            start = 1'b0;
            compared++;
            if (done !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL single_done op %b: got %b expected 1", v_op[i], done);
            end
            expected = exp_q.pop_front();
            compared++;
            if (result !== expected) begin
                mismatched++;
                $display("[TB] FAIL single_result op %b: got %h expected %h", v_op[i], result, expected);
            end
            @(negedge clk);
            compared++;
            if (done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL single_done_pulse op %b: got %b expected 0", v_op[i], done);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] expected;
        logic [7:0] acc;
        apply_stimulus(OP_CLR, 4'h7, 4'h7, 1'b1, 8'h00);
        @(negedge clk);
        start = 1'b0;
        expected = exp_q.pop_front();
        compared++;
        if (done !== 1'b1 || result !== expected) begin
            mismatched++;
            $display("[TB] FAIL clr: got done=%b result=%h expected done=1 result=%h", done, result, expected);
        end
        acc = expected;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(OP_ADD, 4'h3, 4'hF, 1'b0, 8'({1'b0, 4'h3} + {1'b0, acc[3:0]}));
            @(negedge clk);
            compared++;
            if (done !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL accum_done step %0d: got %b expected 1", k, done);
            end
            expected = exp_q.pop_front();
            compared++;
            if (result !== expected) begin
                mismatched++;
                $display("[TB] FAIL accum_result step %0d: got %h expected %h", k, result, expected);
            end
            acc = expected;
        end
        start = 1'b0;
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL accum_done_end: got %b expected 0", done);
        end
    endtask

    task automatic test_mul();
        logic [7:0] expected;
        int lat;
        int busy_cycles;
        apply_stimulus(OP_MUL, 4'hF, 4'hF, 1'b1, 8'hE1);
        lat = 0;
        busy_cycles = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                apply_stimulus(OP_ADD, 4'h1, 4'h1, 1'b1, 8'h00);
                void'(exp_q.pop_back());
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cycles++;
            compared++;
            if (result !== 8'h09) begin
                mismatched++;
                $display("[TB] FAIL mul_hold lat %0d: got %h expected %h", lat, result, 8'h09);
            end
        end
        start = 1'b0;
        compared++;
        if (lat != 5) begin
            mismatched++;
            $display("[TB] FAIL mul_latency: got %0d negedges expected 5", lat);
        end
        compared++;
        if (busy_cycles != 4) begin
            mismatched++;
            $display("[TB] FAIL mul_busy_cycles: got %0d expected 4", busy_cycles);
        end
        expected = exp_q.pop_front();
        compared++;
        if (result !== expected || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mul_result: got %h busy=%b expected %h busy=0", result, busy, expected);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || result !== expected) begin
            mismatched++;
            $display("[TB] FAIL mul_ignored_start: got done=%b result=%h expected done=0 result=%h", done, result, expected);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] expected;
        int lat;
        apply_stimulus(OP_MUL, 4'h7, 4'h9, 1'b1, 8'h3F);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        compared++;
        if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_state: got busy=%b done=%b result=%h expected 0/0/00", busy, done, result);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0 || result !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL abort_no_done cycle %0d: got done=%b result=%h expected 0/00", i, done, result);
            end
        end
        apply_stimulus(OP_MUL, 4'h7, 4'h9, 1'b1, 8'h3F);
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (done === 1'b1) break;
        end
        compared++;
        if (lat != 5) begin
            mismatched++;
            $display("[TB] FAIL remul_latency: got %0d negedges expected 5", lat);
        end
        expected = exp_q.pop_front();
        compared++;
        if (result !== expected) begin
            mismatched++;
            $display("[TB] FAIL remul_result: got %h expected %h", result, expected);
        end
    endtask

    task automatic test_any_all();
        logic [2:0] v_op [3];
        logic [3:0] v_a  [3];
        logic [3:0] v_b  [3];
        logic [7:0] v_e  [3];
        logic [7:0] expected;
        v_op = '{OP_ANY, OP_ALL, OP_ALL};
        v_a  = '{4'h0, 4'hF, 4'hF};
        v_b  = '{4'h0, 4'hF, 4'hE};
        v_e  = '{8'h00, 8'h01, 8'h00};
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(v_op[i], v_a[i], v_b[i], 1'b1, v_e[i]);
            @(negedge clk);
            start = 1'b0;
            expected = exp_q.pop_front();
            compared++;
            if (done !== 1'b1 || result !== expected) begin
                mismatched++;
                $display("[TB] FAIL any_all %0d: got done=%b result=%h expected done=1 result=%h", i, done, result, expected);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        op         = 3'b000;
        a_in       = 4'h0;
        b_in       = 4'h0;
        b_sel      = 1'b1;
        test_reset();
        test_single_ops();
        test_accumulate();
        test_mul();
        test_reset_mid_mul();
        test_any_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq_accum.md
Name: alu_seq_accum

Overview:
- Parametrised, registered successor to the 4-bit combinational lab ALU. It keeps the 8-way opcode-select scheme and adds:
  - a result/accumulator register,
  - a start/busy/done handshake,
  - a subtract op,
  - a multi-cycle shift-add multiply.
- Sits between switch/board inputs and the LED/HEX display logic.
- Feeds its own low half back as operand B for accumulate chains.

Parameters:
- WIDTH, 4, operand width in bits; minimum 2; result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge only while not busy.
- op  input  3  opcode, captured with start.
- a_in  input  WIDTH  operand A, captured with start.
- b_in  input  WIDTH  external operand B.
- b_sel  input  1  1: B = b_in; 0: B = result[WIDTH-1:0] (accumulator). Captured with start.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse coinciding with the cycle in which the new result is first visible.
- result  output  2*WIDTH  registered result / accumulator.

Behaviour:
- Interface: one clock (clk); reset (resetn) is asynchronous and active-low.
- Reset: result = 0, busy = 0, done = 0, FSM = IDLE, internal operand/counter registers = 0. Reset mid-multiply aborts it; no done is issued for the aborted operation.
- FSM states are IDLE and MUL.
  - IDLE with start = 1:
    - capture A and B (B resolved per b_sel from the current result value) and op;
    - op != 110: result updated at the same edge and done = 1 for the following cycle; stay in IDLE;
    - op = 110: go to MUL, busy = 1.
  - MUL: one shift-add step per cycle for WIDTH cycles. At the WIDTH-th edge after the start edge:
    - result <= product, done = 1, busy = 0, return to IDLE.
- Opcodes (unsigned, W = WIDTH):
  - 000 ADD: result = zero-extend(A + B) in W+1 bits; bit W is the carry.
  - 001 SUB: result[W-1:0] = (A - B) mod 2^W; result[W] = borrow (A < B); upper bits 0.
  - 010 XOR_OR: result = {A | B, A ^ B}.
  - 011 ANY: result = zero-extend(|{A,B}).
  - 100 ALL: result = zero-extend(&{A,B}).
  - 101 CAT: result = {A, B}.
  - 110 MUL: result = A * B, full 2W bits, latency W cycles.
  - 111 CLR: result = 0 (done still pulses).
- Latency:
  - single-cycle ops: result visible 1 cycle after the start edge;
  - MUL: result visible W cycles after the start edge.
- Start while busy: ignored entirely; the operation is not queued.
- Back-to-back: start may be high in the done cycle; it is accepted as a new request when the FSM is IDLE.
- result holds its value between operations.
- During MUL, result is not modified until completion; partial products live in internal registers only.
- Accumulator feedback: b_sel = 0 uses result[W-1:0] as of the start edge. The previous upper half is discarded.
- done never asserts without a preceding accepted start.

Decomposition:
- Shared package alu_pkg:
  - 3-bit opcode localparams OP_ADD … OP_CLR;
  - FSM state encodings S_IDLE, S_MUL.
- One sub-module: mul_shift_add (parameter WIDTH).
  - Inputs: clk, resetn, go, a, b.
  - Outputs: busy, valid, product[2*WIDTH-1:0].
  - Iterative, one bit per cycle; valid is a one-cycle pulse.
- Top-level holds the opcode decode, accumulator register and done generation.

Test Plan:
- All tests use WIDTH=4.
- Reset: hold resetn=0 with start=1, op=000 -> result=8'h00, busy=0, done=0; release -> no done until the first start.
- ADD/SUB/CAT/XOR_OR with b_sel=1, checking done exactly 1 cycle after start each time:
  - a=F, b=1, ADD -> 8'h10;
  - a=2, b=5, SUB -> 8'h1D;
  - a=A, b=5, CAT -> 8'hA5;
  - a=C, b=A, XOR_OR -> 8'hE6.
- Accumulate: CLR, then ADD a=3 with b_sel=0 three times back-to-back -> result 03, 06, 09; done high in three consecutive cycles.
- MUL: a=F, b=F -> busy high 4 cycles, result=8'hE1 on the 4th edge after start with a done pulse. A second start (op=000) during busy is ignored and result stays E1.
- Reset mid-MUL: a=7, b=9 MUL, drop resetn after 2 cycles -> busy=0, result=0, no done; a fresh MUL gives 8'h3F.
- ANY/ALL: a=0, b=0 ANY -> 00; a=F, b=F ALL -> 01; a=F, b=E ALL -> 00.
